// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan reader.
package seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t      SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} codes for hex digits 0..F
  localparam seg7_t HEX_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_reader_if.sv
// Register-bank inputs and display pins of the scan reader.
interface seg_scan_reader_if;
  import seg_pkg::*;

  logic       en;
  logic [3:0] in0;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [3:0] in3;
  logic [3:0] blank_mask;
  logic [1:0] cursor;
  logic       cursor_en;
  logic [3:0] an;
  seg7_t      seg;
  logic       dp;
  logic [1:0] digit_idx;

  modport master (
    output en, in0, in1, in2, in3, blank_mask, cursor, cursor_en,
    input  an, seg, dp, digit_idx
  );

  modport slave (
    input  en, in0, in1, in2, in3, blank_mask, cursor, cursor_en,
    output an, seg, dp, digit_idx
  );

endinterface

// File: rtl/seg_scan_reader_hex_to_seg7.sv
// Combinational hex-nibble to seven-segment decoder, selectable polarity.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       active_low,
  output seg7_t      seg
);

  always_comb begin
    seg = HEX_AL[nibble];
    if (!active_low) seg = ~HEX_AL[nibble];
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Time-multiplexes four nibbles onto a 4-digit display with a dp cursor.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             reset,
  seg_scan_reader_if.slave bus
);

  localparam int              CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]   PRE_MAX = CW'(REFRESH_DIV - 1);
  // Outputs are built in active-low form, then XORed with POL for the pins
  localparam logic            POL     = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic            DEC_AL  = (ACTIVE_LOW != 0);

  logic [CW-1:0] pre_cnt;
  logic [1:0]    idx;
  logic          tick;

  logic [3:0]    nib;
  logic          blank;
  logic          cur_hit;
  seg7_t         seg_dec;
  logic [3:0]    an_nxt;
  seg7_t         seg_nxt;
  logic          dp_nxt;

  assign tick          = bus.en && (pre_cnt == PRE_MAX);
  assign bus.digit_idx = idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else if (bus.en) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  always_comb begin
    nib = bus.in0;
    case (idx)
      2'd0: nib = bus.in0;
      2'd1: nib = bus.in1;
      2'd2: nib = bus.in2;
      2'd3: nib = bus.in3;
      default: nib = bus.in0;
    endcase
  end

  hex_to_seg7 u_dec (
    .nibble     (nib),
    .active_low (DEC_AL),
    .seg        (seg_dec)
  );

  always_comb begin
    blank   = bus.blank_mask[idx];
    cur_hit = bus.cursor_en && (bus.cursor == idx) && !blank;
    an_nxt  = (blank ? AN_OFF : ~(4'b0001 << idx)) ^ {4{POL}};
    seg_nxt = blank ? (SEG_OFF ^ {7{POL}}) : seg_dec;
    dp_nxt  = ~cur_hit ^ POL;
  end

  // Output register: every cycle, so frozen scans still track input changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.an  <= AN_OFF ^ {4{POL}};
      bus.seg <= SEG_OFF ^ {7{POL}};
      bus.dp  <= 1'b1 ^ POL;
    end else begin
      bus.an  <= an_nxt;
      bus.seg <= seg_nxt;
      bus.dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Scoreboard bench for seg_scan_reader, REFRESH_DIV=4, ACTIVE_LOW=1.
module tb_seg_scan_reader;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [3:0] WALK [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_scan_reader_if bus ();

  seg_scan_reader #(.REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  obs_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_idx  = 0;
  int   m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic obs_t expect_now();
    obs_t r;
    logic [3:0] n;
    case (m_idx)
      0: n = bus.in0;
      1: n = bus.in1;
      2: n = bus.in2;
      default: n = bus.in3;
    endcase
    if (bus.blank_mask[m_idx]) begin
      r.an = 4'hF; r.seg = 7'h7F; r.dp = 1'b1;
    end else begin
      r.an  = WALK[m_idx];
      r.seg = HEX[n];
      r.dp  = !(bus.cursor_en && (bus.cursor == 2'(m_idx)));
    end
    return r;
  endfunction

  // One clock: predict at the edge, compare on the following falling edge
  task automatic cyc();
    obs_t e;
    @(posedge clk);
    q.push_back(expect_now());
    if (bus.en) begin
      if (m_cnt == 3) begin m_cnt = 0; m_idx = (m_idx + 1) % 4; end
      else m_cnt++;
    end
    @(negedge clk);
    e = q.pop_front();
    chk("an", bus.an, e.an);
    chk("seg", bus.seg, e.seg);
    chk("dp", bus.dp, e.dp);
    chk("digit_idx", bus.digit_idx, m_idx);
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_an"}, bus.an, 4'hF);
    chk({tag, "_seg"}, bus.seg, 7'h7F);
    chk({tag, "_dp"}, bus.dp, 1'b1);
    chk({tag, "_idx"}, bus.digit_idx, 2'd0);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    bus.en = 1'b1; bus.in0 = 4'd0; bus.in1 = 4'd1; bus.in2 = 4'd2; bus.in3 = 4'd3;
    bus.blank_mask = 4'b0000; bus.cursor = 2'd0; bus.cursor_en = 1'b0;
    repeat (2) @(negedge clk);
    check_dark("reset");
    reset = 1'b0;
    m_idx = 0; m_cnt = 0;

    // Scan walk with in3..in0 = 3,2,1,0
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("walk_an", bus.an, WALK[((k - 1) / 4) % 4]);
      chk("walk_seg", bus.seg, HEX[((k - 1) / 4) % 4]);
    end

    // Frozen scan on digit 0, sweep in0
    for (int i = 0; i < 40 && !(m_idx == 0); i++) cyc();
    chk("reach_idx0", m_idx, 0);
    bus.en = 1'b0;
    for (int v = 0; v < 16; v++) begin
      bus.in0 = 4'(v);
      cyc();
      chk("sweep_an", bus.an, 4'hE);
      chk("sweep_seg", bus.seg, HEX[v]);
    end
    bus.in0 = 4'd0;
    bus.en  = 1'b1;

    // Blank digit 2
    bus.blank_mask = 4'b0100;
    cnt = 0;
    repeat (16) begin
      cyc();
      if (bus.an == 4'hF) cnt++;
    end
    chk("blank_count", cnt, 4);
    bus.blank_mask = 4'b0000;

    // Cursor on digit 1
    bus.cursor = 2'd1; bus.cursor_en = 1'b1;
    cnt = 0;
    repeat (16) begin
      cyc();
      if (bus.dp == 1'b0) begin
        cnt++;
        chk("dp_on_digit1", bus.an, 4'hD);
      end
    end
    chk("dp_count_en", cnt, 4);
    bus.cursor_en = 1'b0;
    cnt = 0;
    repeat (16) begin
      cyc();
      if (bus.dp == 1'b0) cnt++;
    end
    chk("dp_count_dis", cnt, 0);

    // en dropped right after the 1->2 tick
    for (int i = 0; i < 40 && !(m_idx == 1 && m_cnt == 3); i++) cyc();
    chk("reach_tick12", (m_idx == 1 && m_cnt == 3), 1'b1);
    cyc();
    bus.en = 1'b0;
    chk("tick12_idx", bus.digit_idx, 2'd2);
    repeat (10) cyc();
    chk("hold_idx", bus.digit_idx, 2'd2);
    bus.en = 1'b1;
    repeat (3) cyc();
    chk("resume_pre", bus.digit_idx, 2'd2);
    cyc();
    chk("resume_tick", bus.digit_idx, 2'd3);

    // Asynchronous reset in the middle of a cycle
    repeat (5) cyc();
    #2 reset = 1'b1;
    #1 check_dark("async_reset");
    repeat (3) begin
      @(negedge clk);
      check_dark("reset_hold");
    end
    reset = 1'b0;
    m_idx = 0; m_cnt = 0;
    repeat (3) cyc();
    chk("restart_pre", bus.digit_idx, 2'd0);
    cyc();
    chk("restart_tick", bus.digit_idx, 2'd1);
    cyc();
    chk("restart_an", bus.an, 4'hD);

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
